// File: rtl/simon_ti_ct_collector_pkg.sv
// simon_ti_pkg: shared constants and FSM state type for the Simon TI
// ciphertext collector.
//   SIMON_BLOCK_BITS : bits per share per block (also the shift count)
//   SIMON_CNT_W      : width of the bit counter, 2**SIMON_CNT_W >= block bits
//   ct_state_t       : collector FSM states
package simon_ti_pkg;
    localparam int SIMON_BLOCK_BITS = 128;
    localparam int SIMON_CNT_W      = 7;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} ct_state_t;
endpackage

// File: rtl/simon_ti_ct_collector_if.sv
// simon_ti_ct_collector_if: stream-in / block-out bundle of the ciphertext
// collector.
//   master : core + host side (drives done_in, bit_ina, bit_inb, ct_ready)
//   slave  : collector side (drives ct_a, ct_b, ct_valid, busy, overrun and,
//            when built with SIMON_CT_UNMASK_EN, ct_plain)
interface simon_ti_ct_collector_if
    import simon_ti_pkg::*;
#(
    parameter int BLOCK_BITS = SIMON_BLOCK_BITS
) ();
    logic                  done_in;
    logic                  bit_ina;
    logic                  bit_inb;
    logic [BLOCK_BITS-1:0] ct_a;
    logic [BLOCK_BITS-1:0] ct_b;
    logic                  ct_valid;
    logic                  ct_ready;
    logic                  busy;
    logic                  overrun;
`ifdef SIMON_CT_UNMASK_EN
    logic [BLOCK_BITS-1:0] ct_plain;

    modport master (output done_in, bit_ina, bit_inb, ct_ready,
                    input  ct_a, ct_b, ct_valid, busy, overrun, ct_plain);
    modport slave  (input  done_in, bit_ina, bit_inb, ct_ready,
                    output ct_a, ct_b, ct_valid, busy, overrun, ct_plain);
`else
    modport master (output done_in, bit_ina, bit_inb, ct_ready,
                    input  ct_a, ct_b, ct_valid, busy, overrun);
    modport slave  (input  done_in, bit_ina, bit_inb, ct_ready,
                    output ct_a, ct_b, ct_valid, busy, overrun);
`endif
endinterface

// File: rtl/simon_ti_ct_collector_sipo.sv
// simon_share_sipo: one-share serial-in/parallel-out register. Shifts right
// with the new bit entering at the MSB, so after BLOCK_BITS shifts bit i of q
// holds the i-th bit received.
//   clk, rst : clock, async active-high reset (clears q)
//   en       : shift one bit this cycle
//   din      : serial bit
//   q        : parallel word
module simon_share_sipo #(
    parameter int BLOCK_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  din,
    output logic [BLOCK_BITS-1:0] q
);
    logic [BLOCK_BITS-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q_q <= '0;
        else if (en) q_q <= {din, q_q[BLOCK_BITS-1:1]};
    end

    assign q = q_q;
endmodule

// File: rtl/simon_ti_ct_collector.sv
// simon_ti_ct_collector: deserialises the 2-share bit-serial ciphertext from
// the TI Simon core (LSB first, starting on the rising edge of done_in) into
// two BLOCK_BITS-wide words and offers them on a valid/ready port.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of simon_ti_ct_collector_if
// Build option SIMON_CT_UNMASK_EN adds ct_plain = ct_a ^ ct_b, registered on
// HOLD entry. Without it the shares are never combined inside this block.
module simon_ti_ct_collector
    import simon_ti_pkg::*;
#(
    parameter int BLOCK_BITS = SIMON_BLOCK_BITS,
    parameter int CNT_W      = SIMON_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    simon_ti_ct_collector_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BITS - 1);

    ct_state_t             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  valid_q;
    logic                  overrun_q;

    logic                  done_rise;
    logic                  shift_en;
    logic                  last_bit;
    logic [1:0]            sh_bit;
    logic [1:0][BLOCK_BITS-1:0] sh_q;

    assign done_rise = bus.done_in & ~done_q;
    // Bit 0 is on the wire in the same cycle as the Done edge, so IDLE shifts too.
    assign shift_en  = (state_q == ST_SHIFT) || ((state_q == ST_IDLE) && done_rise);
    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign sh_bit    = {bus.bit_inb, bus.bit_ina};

    // One register per share; the shares never meet in a common register.
    for (genvar s = 0; s < 2; s++) begin : g_share
        simon_share_sipo #(.BLOCK_BITS(BLOCK_BITS)) u_sipo (
            .clk (clk),
            .rst (rst),
            .en  (shift_en),
            .din (sh_bit[s]),
            .q   (sh_q[s])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= bus.done_in;
            case (state_q)
                ST_IDLE: begin
                    if (done_rise) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Done edges/levels are ignored here; the count always completes.
                    if (last_bit) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // A new stream can only start from IDLE, so an edge here is lost.
                    if (done_rise) overrun_q <= 1'b1;
                    if (valid_q && bus.ct_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ct_a     = sh_q[0];
    assign bus.ct_b     = sh_q[1];
    assign bus.ct_valid = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

`ifdef SIMON_CT_UNMASK_EN
    logic [BLOCK_BITS-1:0] plain_q;

    // Combine the words as they will look after the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           plain_q <= '0;
        else if (last_bit) plain_q <= {bus.bit_ina, sh_q[0][BLOCK_BITS-1:1]}
                                    ^ {bus.bit_inb, sh_q[1][BLOCK_BITS-1:1]};
    end

    assign bus.ct_plain = plain_q;
`endif
endmodule

// File: tb/tb_simon_ti_ct_collector.sv
module tb_simon_ti_ct_collector;
    localparam int BB = 128;
    localparam logic [BB-1:0] KAT_CT = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simon_ti_ct_collector_if #(.BLOCK_BITS(BB)) bus ();

    simon_ti_ct_collector #(.BLOCK_BITS(BB), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp = 0;
    int nerr = 0;

    // Reference state: the last block that should be on ct_a/ct_b and the
    // sticky overrun flag.
    logic [BB-1:0] exp_a = '0;
    logic [BB-1:0] exp_b = '0;
    logic          exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BB-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stream one block LSB-first from a fresh Done edge. If abort_at > 0 the
    // reset is pulsed while bit abort_at is due and the block is abandoned.
    task automatic send_block(input logic [BB-1:0] a, input logic [BB-1:0] b, input int abort_at);
        int busy_cnt = 0;
        int early_valid = 0;
        bus.done_in = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 1'b0);
        bus.done_in = 1'b1;
        bus.bit_ina = a[0];
        bus.bit_inb = b[0];
        for (int k = 1; k < BB; k++) begin
            tick();
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.ct_valid !== 1'b0) early_valid++;
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_ct_a", bus.ct_a, '0);
                chk("rst_ct_b", bus.ct_b, '0);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_valid", bus.ct_valid, 1'b0);
                chk("rst_overrun", bus.overrun, 1'b0);
`ifdef SIMON_CT_UNMASK_EN
                chk("rst_plain", bus.ct_plain, '0);
`endif
                bus.done_in = 1'b0;
                rst = 1'b0;
                exp_a = '0;
                exp_b = '0;
                exp_ovr = 1'b0;
                return;
            end
            bus.bit_ina = a[k];
            bus.bit_inb = b[k];
        end
        tick();
        chk("busy_cycles", busy_cnt, BB - 1);
        chk("early_valid", early_valid, 0);
        chk("valid_rise", bus.ct_valid, 1'b1);
        chk("busy_end", bus.busy, 1'b0);
        chk("ct_a", bus.ct_a, a);
        chk("ct_b", bus.ct_b, b);
`ifdef SIMON_CT_UNMASK_EN
        chk("ct_plain", bus.ct_plain, a ^ b);
`endif
        exp_a = a;
        exp_b = b;
    endtask

    // Hold ct_ready low for 'hold' cycles, then accept the block.
    task automatic accept(input int hold);
        int unstable = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.ct_valid !== 1'b1 || bus.ct_a !== exp_a || bus.ct_b !== exp_b) unstable++;
        end
        chk("hold_stable", unstable, 0);
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;
        chk("accept_valid", bus.ct_valid, 1'b0);
        chk("accept_busy", bus.busy, 1'b0);
        chk("accept_ct_a", bus.ct_a, exp_a);
        chk("overrun", bus.overrun, exp_ovr);
    endtask

    // Run n cycles and report how many showed busy or ct_valid.
    task automatic idle_run(input int n, input logic random_bits, output int activity);
        activity = 0;
        for (int i = 0; i < n; i++) begin
            if (random_bits) begin
                bus.bit_ina  = 1'($urandom());
                bus.bit_inb  = 1'($urandom());
                bus.ct_ready = 1'($urandom());
            end
            tick();
            if (bus.busy !== 1'b0 || bus.ct_valid !== 1'b0) activity++;
        end
        bus.ct_ready = 1'b0;
    endtask

    initial begin
        int act;
        logic [BB-1:0] ones;
        rst          = 1'b1;
        bus.done_in  = 1'b0;
        bus.bit_ina  = 1'b0;
        bus.bit_inb  = 1'b0;
        bus.ct_ready = 1'b0;
        ones         = '1;
        tick();
        tick();
        chk("reset_valid", bus.ct_valid, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_overrun", bus.overrun, 1'b0);
        chk("reset_ct_a", bus.ct_a, '0);
        chk("reset_ct_b", bus.ct_b, '0);
        rst = 1'b0;
        tick();

        // Basic unmasked block.
        send_block(KAT_CT, '0, 0);
        accept(3);

        // Masked block: B is the complement of the basic ciphertext, so the
        // unmasked value of all-ones ^ B is that ciphertext again.
        send_block(ones, ~KAT_CT, 0);
`ifdef SIMON_CT_UNMASK_EN
        chk("kat_plain", bus.ct_plain, KAT_CT);
`endif
        accept(0);

        // Backpressure.
        send_block(rnd128(), rnd128(), 0);
        accept(50);

        // Done edge while holding: dropped, overrun set, data untouched.
        send_block(rnd128(), rnd128(), 0);
        chk("pre_overrun", bus.overrun, 1'b0);
        bus.done_in = 1'b0;
        tick();
        bus.done_in = 1'b1;
        tick();
        exp_ovr = 1'b1;
        chk("overrun_set", bus.overrun, 1'b1);
        chk("overrun_valid", bus.ct_valid, 1'b1);
        chk("overrun_ct_a", bus.ct_a, exp_a);
        accept(2);
        idle_run(140, 1'b1, act);
        chk("overrun_no_block", act, 0);

        // Done edge in the same cycle as the accept: accepted, stream dropped.
        send_block(rnd128(), rnd128(), 0);
        bus.done_in = 1'b0;
        tick();
        bus.done_in  = 1'b1;
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;
        chk("acc_rise_valid", bus.ct_valid, 1'b0);
        idle_run(140, 1'b1, act);
        chk("acc_rise_no_block", act, 0);
        chk("acc_rise_ct_a", bus.ct_a, exp_a);

        // Reset in the middle of SHIFT, then a clean block.
        send_block(rnd128(), rnd128(), 60);
        tick();
        chk("post_rst_busy", bus.busy, 1'b0);
        send_block(rnd128(), rnd128(), 0);
        accept(1);

        // Done held high across a second stream: only one block collected.
        send_block(rnd128(), rnd128(), 0);
        accept(0);
        idle_run(BB + 10, 1'b1, act);
        chk("held_done_no_block", act, 0);
        chk("held_done_ct_a", bus.ct_a, exp_a);
        chk("held_done_ct_b", bus.ct_b, exp_b);

        // Random blocks with random backpressure.
        for (int n = 0; n < 4; n++) begin
            send_block(rnd128(), rnd128(), 0);
            accept(int'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
